// File: rtl/metro_pkg.sv
// Metro card reader shared types and constants.
// Frame geometry, timer limits, reader states, result codes.
package metro_pkg;

  localparam int CODE_W        = 4;
  localparam int FRAME_TIMEOUT = 16;
  localparam int RESP_TIMEOUT  = 8;
  localparam int HOLDOFF       = 4;
  localparam int FRAME_BITS    = CODE_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } rd_state_e;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_GRANT = 2'b01;
  localparam logic [1:0] RES_DENY  = 2'b10;
  localparam logic [1:0] RES_ERR   = 2'b11;

endpackage

// File: rtl/metro_rx_deser.sv
// Card frame deserialiser: shifts data bits, counts frame bits,
// checks even parity on the final bit and times gaps between bits.
module metro_rx_deser
  import metro_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              rx_valid_i,
  input  logic              rx_bit_i,
  output logic [CODE_W-1:0] data_o,
  output logic              frame_done_o,
  output logic              parity_ok_o,
  output logic              gap_err_o
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int GW = $clog2(FRAME_TIMEOUT + 1);

  logic [CODE_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [GW-1:0]     gap_q, gap_d;

  // Shift/count on each strobe, age the gap timer otherwise.
  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    if (clr_i) begin
      shift_d = '0;
      bit_d   = '0;
      gap_d   = '0;
    end else if (en_i) begin
      if (rx_valid_i) begin
        shift_d = {shift_q[CODE_W-2:0], rx_bit_i};
        bit_d   = bit_q + 1'b1;
        gap_d   = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  // Deserialiser state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      shift_q <= shift_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
    end
  end

  // The parity bit is checked live; shift_q still holds the data.
  always_comb begin
    data_o       = shift_q;
    frame_done_o = en_i & rx_valid_i &
                   (bit_q == BW'(FRAME_BITS - 1));
    parity_ok_o  = ((^shift_q) == rx_bit_i);
    gap_err_o    = en_i & ~rx_valid_i &
                   (gap_q == GW'(FRAME_TIMEOUT - 1));
  end

endmodule

// File: rtl/metro_card_reader.sv
// Card reader front end: frame capture, validate pulse to the
// turnstile, response timing and result reporting with holdoff.
module metro_card_reader
  import metro_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic              rx_bit,
  input  logic              open_access_door,
  output logic [CODE_W-1:0] access_code,
  output logic              validate_code,
  output logic              busy,
  output logic [1:0]        result,
  output logic              result_valid
);

  localparam int RW = $clog2(RESP_TIMEOUT + 1);
  localparam int HW = $clog2(HOLDOFF + 1);

  rd_state_e         state_q, state_d;
  logic [RW-1:0]     resp_q, resp_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [1:0]        res_q, res_d;
  logic              rv_q, rv_d;
  logic [1:0]        res_code;

  logic [CODE_W-1:0] rx_data;
  logic              frame_done;
  logic              parity_ok;
  logic              gap_err;
  logic              start;

  assign start = (state_q == ST_IDLE) & rx_valid & rx_bit;

  metro_rx_deser u_deser (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start),
    .en_i         (state_q == ST_RECV),
    .rx_valid_i   (rx_valid),
    .rx_bit_i     (rx_bit),
    .data_o       (rx_data),
    .frame_done_o (frame_done),
    .parity_ok_o  (parity_ok),
    .gap_err_o    (gap_err)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and the result code for a HOLD entry.
  always_comb begin
    state_d  = state_q;
    res_code = RES_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RECV;
      end
      ST_RECV: begin
        res_code = RES_ERR;
        if (frame_done)
          state_d = parity_ok ? ST_ISSUE : ST_HOLD;
        else if (gap_err)
          state_d = ST_HOLD;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        res_code = open_access_door ? RES_GRANT : RES_DENY;
        if (open_access_door ||
            resp_q == RW'(RESP_TIMEOUT - 1))
          state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_q == HW'(HOLDOFF - 1))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timers run only while staying in their state, so each
  // restarts from zero on entry.
  always_comb begin
    resp_d = '0;
    hold_d = '0;
    if (state_q == ST_WAIT && state_d == ST_WAIT)
      resp_d = resp_q + 1'b1;
    if (state_q == ST_HOLD && state_d == ST_HOLD)
      hold_d = hold_q + 1'b1;
  end

  // Latch the code as ISSUE is entered; report on HOLD entry.
  always_comb begin
    code_d = code_q;
    if (state_q == ST_RECV && state_d == ST_ISSUE)
      code_d = rx_data;
    rv_d  = (state_d == ST_HOLD) & (state_q != ST_HOLD);
    res_d = rv_d ? res_code : res_q;
  end

  // Timer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q <= '0;
      hold_q <= '0;
      code_q <= '0;
      res_q  <= RES_NONE;
      rv_q   <= 1'b0;
    end else begin
      resp_q <= resp_d;
      hold_q <= hold_d;
      code_q <= code_d;
      res_q  <= res_d;
      rv_q   <= rv_d;
    end
  end

  // Outputs decoded from the state and output registers.
  always_comb begin
    busy          = (state_q != ST_IDLE);
    validate_code = (state_q == ST_ISSUE);
    access_code   = code_q;
    result        = res_q;
    result_valid  = rv_q;
  end

endmodule

// File: tb/tb_metro_card_reader.sv
// Self-checking bench for metro_card_reader: cycle vector table
// plus hand sequences for asynchronous reset mid-frame/mid-wait.
module tb_metro_card_reader;

  localparam logic [1:0] R_NONE  = 2'b00;
  localparam logic [1:0] R_GRANT = 2'b01;
  localparam logic [1:0] R_DENY  = 2'b10;
  localparam logic [1:0] R_ERR   = 2'b11;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic       rx_bit;
  logic       open_access_door;
  logic [3:0] access_code;
  logic       validate_code;
  logic       busy;
  logic [1:0] result;
  logic       result_valid;

  int n_run;
  int n_fail;

  typedef struct {
    bit         rv;
    bit         rb;
    bit         dr;
    bit         ev;
    bit         eb;
    bit         erv;
    logic [3:0] ec;
    logic [1:0] er;
    string      nm;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] m_code;
  logic [1:0] m_res;

  metro_card_reader dut (
    .clk              (clk),
    .rst              (rst),
    .rx_valid         (rx_valid),
    .rx_bit           (rx_bit),
    .open_access_door (open_access_door),
    .access_code      (access_code),
    .validate_code    (validate_code),
    .busy             (busy),
    .result           (result),
    .result_valid     (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic ev,
                       input logic [3:0] ec, input logic eb,
                       input logic erv, input logic [1:0] er);
    n_run++;
    if (validate_code !== ev || access_code !== ec ||
        busy !== eb || result_valid !== erv ||
        result !== er) begin
      n_fail++;
      $display("FAIL %s: got v=%0b code=%0d busy=%0b rv=%0b res=%b, want v=%0b code=%0d busy=%0b rv=%0b res=%b",
               nm, validate_code, access_code, busy,
               result_valid, result, ev, ec, eb, erv, er);
    end
  endtask

  // Drive one cycle of inputs, check mid-cycle, advance.
  task automatic cyc(input bit rv, input bit rb, input bit dr,
                     input logic ev, input logic [3:0] ec,
                     input logic eb, input logic erv,
                     input logic [1:0] er, input string nm);
    rx_valid         = rv;
    rx_bit           = rb;
    open_access_door = dr;
    @(negedge clk);
    check(nm, ev, ec, eb, erv, er);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit rv, input bit rb, input bit dr,
                     input bit ev, input bit eb, input bit erv,
                     input string nm);
    vec_t v;
    v.rv = rv; v.rb = rb; v.dr = dr;
    v.ev = ev; v.eb = eb; v.erv = erv;
    v.ec = m_code; v.er = m_res; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic add_frame(input logic [3:0] d, input bit par);
    logic [3:0] dd;
    dd = d;
    add(1, 1, 0, 0, 0, 0, "start");
    for (int i = 3; i >= 0; i--)
      add(1, dd[i], 0, 0, 1, 0, "data");
    add(1, par, 0, 0, 1, 0, "parity");
  endtask

  task automatic add_issue(input logic [3:0] d);
    m_code = d;
    add(0, 0, 0, 1, 1, 0, "issue");
  endtask

  task automatic add_hold(input logic [1:0] r);
    m_res = r;
    add(0, 0, 0, 0, 1, 1, "hold_entry");
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 1, 0, "hold");
    add(0, 0, 0, 0, 0, 0, "back_idle");
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    m_code = 4'd0;
    m_res = R_NONE;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_bit = 1'b0;
    open_access_door = 1'b0;

    // Grant: code 9, door high on third wait cycle.
    add_frame(4'd9, 1'b0);
    add_issue(4'd9);
    add(0, 0, 0, 0, 1, 0, "wait");
    add(0, 0, 0, 0, 1, 0, "wait");
    add(0, 0, 1, 0, 1, 0, "wait_door");
    add_hold(R_GRANT);
    // Bad parity: no validate, frame error.
    add_frame(4'd9, 1'b1);
    add_hold(R_ERR);
    // Leading zeros ignored, then gap timeout.
    add(1, 0, 0, 0, 0, 0, "lead0");
    add(1, 0, 0, 0, 0, 0, "lead0");
    add(1, 1, 0, 0, 0, 0, "start");
    add(1, 1, 0, 0, 1, 0, "data");
    add(1, 0, 0, 0, 1, 0, "data");
    for (int i = 0; i < 16; i++)
      add(0, 0, 0, 0, 1, 0, "gap");
    add_hold(R_ERR);
    // Deny: code 2, door low through timeout.
    add_frame(4'd2, 1'b1);
    add_issue(4'd2);
    for (int i = 0; i < 8; i++)
      add(0, 0, 0, 0, 1, 0, "wait_nodoor");
    add_hold(R_DENY);
    // Bits during HOLD ignored; frame right after decodes.
    add_frame(4'd9, 1'b1);
    m_res = R_ERR;
    add(1, 1, 0, 0, 1, 1, "hold_entry_rx");
    add(1, 1, 0, 0, 1, 0, "hold_rx");
    add(1, 0, 0, 0, 1, 0, "hold_rx");
    add(1, 1, 0, 0, 1, 0, "hold_rx");
    add_frame(4'd5, 1'b0);
    add_issue(4'd5);
    add(0, 0, 1, 0, 1, 0, "wait_door");
    add_hold(R_GRANT);

    repeat (2) @(negedge clk);
    check("reset", 0, 4'd0, 0, 0, R_NONE);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].rv, tbl[i].rb, tbl[i].dr, tbl[i].ev,
          tbl[i].ec, tbl[i].eb, tbl[i].erv, tbl[i].er,
          $sformatf("%s[%0d]", tbl[i].nm, i));

    // Reset in the middle of RECV.
    cyc(1, 1, 0, 0, 4'd5, 0, 0, R_GRANT, "r1_start");
    cyc(1, 0, 0, 0, 4'd5, 1, 0, R_GRANT, "r1_data");
    cyc(1, 1, 0, 0, 4'd5, 1, 0, R_GRANT, "r1_data");
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_bit = 1'b0;
    #1;
    check("rst_mid_recv", 0, 4'd0, 0, 0, R_NONE);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 4'd0, 0, 0, R_NONE, "post_rst1");
    cyc(1, 1, 0, 0, 4'd0, 0, 0, R_NONE, "f9_start");
    cyc(1, 1, 0, 0, 4'd0, 1, 0, R_NONE, "f9_d");
    cyc(1, 0, 0, 0, 4'd0, 1, 0, R_NONE, "f9_d");
    cyc(1, 0, 0, 0, 4'd0, 1, 0, R_NONE, "f9_d");
    cyc(1, 1, 0, 0, 4'd0, 1, 0, R_NONE, "f9_d");
    cyc(1, 0, 0, 0, 4'd0, 1, 0, R_NONE, "f9_p");
    cyc(0, 0, 0, 1, 4'd9, 1, 0, R_NONE, "f9_issue");
    cyc(0, 0, 0, 0, 4'd9, 1, 0, R_NONE, "f9_wait");

    // Reset in the middle of WAIT_RESP.
    rst = 1'b1;
    #1;
    check("rst_mid_wait", 0, 4'd0, 0, 0, R_NONE);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 1, 0, 4'd0, 0, 0, R_NONE, "post_rst2");
    cyc(1, 1, 0, 0, 4'd0, 0, 0, R_NONE, "f5_start");
    cyc(1, 0, 0, 0, 4'd0, 1, 0, R_NONE, "f5_d");
    cyc(1, 1, 0, 0, 4'd0, 1, 0, R_NONE, "f5_d");
    cyc(1, 0, 0, 0, 4'd0, 1, 0, R_NONE, "f5_d");
    cyc(1, 1, 0, 0, 4'd0, 1, 0, R_NONE, "f5_d");
    cyc(1, 0, 0, 0, 4'd0, 1, 0, R_NONE, "f5_p");
    cyc(0, 0, 0, 1, 4'd5, 1, 0, R_NONE, "f5_issue");
    cyc(0, 0, 1, 0, 4'd5, 1, 0, R_NONE, "f5_door");
    cyc(0, 0, 0, 0, 4'd5, 1, 1, R_GRANT, "f5_grant");
    cyc(0, 0, 0, 0, 4'd5, 1, 0, R_GRANT, "f5_hold");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
